// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/state enums and sign-magnitude <-> two's-complement helpers
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_AND = 3'b110,
        OP_OR  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_e;

    // Wide enough for a (w+1)-bit two's-complement value at the largest legal width.
    localparam int TCW = 33;

    function automatic logic [TCW-1:0] sm_to_tc(input logic [TCW-1:0] sm, input int w);
        logic [TCW-1:0] mag;
        logic           sgn;
        mag = '0;
        sgn = 1'b0;
        for (int i = 0; i < TCW; i++) begin
            if (i < w - 1)
                mag[i] = sm[i];
            else if (i == w - 1)
                sgn = sm[i];
        end
        return sgn ? (~mag + TCW'(1)) : mag;
    endfunction

    // Keeps the low w-1 magnitude bits; a zero magnitude always comes back as +0.
    function automatic logic [TCW-1:0] tc_to_sm(input logic [TCW-1:0] tc, input int w);
        logic [TCW-1:0] mag;
        logic [TCW-1:0] sm;
        mag = tc[TCW-1] ? (~tc + TCW'(1)) : tc;
        sm  = '0;
        for (int i = 0; i < TCW; i++) begin
            if (i < w - 1)
                sm[i] = mag[i];
            else if (i == w - 1)
                sm[i] = tc[TCW-1] && (mag != '0);
        end
        return sm;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiply and restoring divide on magnitudes
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [N-2:0]   a_mag,
    input  logic [N-2:0]   b_mag,
    output logic           last,
    output logic [2*N-3:0] prod_nx,
    output logic [N-2:0]   quot_nx
);

    localparam int CW = $clog2(N);

    logic [2*N-3:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [N-2:0]   mplier_q, mplier_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   rem_sh;
    logic           ge;

    assign last = (cnt_q == CW'(N - 2));

    // prod_nx/quot_nx are the values after the current step, so the top can
    // register the final result on the same edge as the last iteration.
    always_comb begin
        prod_nx  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_sh   = {rem_q, quo_q[N-2]};
        ge       = (rem_sh >= {1'b0, dvs_q});
        quot_nx  = {quo_q[N-3:0], ge};

        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = {{(N-1){1'b0}}, a_mag};
            mplier_d = b_mag;
            rem_d    = '0;
            quo_d    = a_mag;
            dvs_d    = b_mag;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = prod_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            rem_d    = (N-1)'(ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh);
            quo_d    = quot_nx;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered sign-magnitude ALU with iterative mul/div and start/busy/done handshake
module alu_seq
    import alu_pkg::*;
#(
    parameter int N   = 6,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   sel,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out,
    output logic         Z,
    output logic         O,
    output logic         C,
    output logic         Nf
);

    localparam logic [TCW-1:0] MAG_MAX = TCW'((64'd1 << (N - 1)) - 64'd1);

    state_e         state_q, state_d;
    logic [N-1:0]   out_q, out_d;
    logic           z_q, z_d, o_q, o_d, c_q, c_d, nf_q, nf_d, done_q, done_d;
    logic           neg_q, neg_d, is_div_q, is_div_d;

    op_e            op;
    logic           accept, multi, load, step, last, cap_sc, cap_md;
    logic [2*N-3:0] prod_nx;
    logic [N-2:0]   quot_nx;

    logic [TCW-1:0] a_tc, b_tc, b_eff, r, r_mag, r_sm;
    logic [SHW-1:0] amt;
    logic           amt_big;
    logic [N:0]     shl_t, shr_t;
    logic [N-1:0]   sc_out, md_out;
    logic           sc_o, sc_c, md_o;
    logic           unused_sm_hi;

    assign op     = op_e'(sel);
    assign multi  = (op == OP_MUL) || ((op == OP_DIV) && (B[N-2:0] != '0));
    assign accept = start && (state_q == ST_IDLE);

    muldiv_iter #(.N(N)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .a_mag   (A[N-2:0]),
        .b_mag   (B[N-2:0]),
        .last    (last),
        .prod_nx (prod_nx),
        .quot_nx (quot_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && multi) state_d = ST_ITER;
            ST_ITER: if (last)            state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_ITER);
        load   = 1'b0;
        step   = 1'b0;
        cap_sc = 1'b0;
        cap_md = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load   = accept && multi;
                cap_sc = accept && !multi;
            end
            ST_ITER: begin
                step   = 1'b1;
                cap_md = last;
            end
            default: ;
        endcase
    end

    // Single-cycle datapath, evaluated straight from the operand inputs.
    always_comb begin
        a_tc    = sm_to_tc(TCW'(A), N);
        b_tc    = sm_to_tc(TCW'(B), N);
        b_eff   = (op == OP_SUB) ? (~b_tc + TCW'(1)) : b_tc;
        r       = a_tc + b_eff;
        r_mag   = r[TCW-1] ? (~r + TCW'(1)) : r;
        r_sm    = tc_to_sm(r, N);
        amt     = B[SHW-1:0];
        amt_big = ({{(32-SHW){1'b0}}, amt} >= 32'(N));
        shl_t   = {1'b0, A} << amt;
        shr_t   = {A, 1'b0} >> amt;

        sc_out = '0;
        sc_o   = 1'b0;
        sc_c   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                sc_out = r_sm[N-1:0];
                sc_o   = (r_mag > MAG_MAX);
                sc_c   = ((({1'b0, a_tc[N-1:0]} + {1'b0, b_eff[N-1:0]}) >> N) != '0);
            end
            OP_DIV: begin
                sc_out = {A[N-1], {(N-1){1'b1}}};
                sc_o   = 1'b1;
            end
            OP_SHL:  if (!amt_big) {sc_c, sc_out} = shl_t;
            OP_SHR:  if (!amt_big) {sc_out, sc_c} = shr_t;
            OP_AND:  sc_out = A & B;
            OP_OR:   sc_out = A | B;
            default: ;
        endcase
    end

    assign unused_sm_hi = ^r_sm[TCW-1:N];

    always_comb begin
        if (is_div_q) begin
            md_out = {neg_q && (quot_nx != '0), quot_nx};
            md_o   = 1'b0;
        end else begin
            md_out = {neg_q && (prod_nx != '0), prod_nx[N-2:0]};
            md_o   = |prod_nx[2*N-3:N-1];
        end
    end

    always_comb begin
        out_d    = out_q;
        z_d      = z_q;
        o_d      = o_q;
        c_d      = c_q;
        nf_d     = nf_q;
        done_d   = 1'b0;
        neg_d    = neg_q;
        is_div_d = is_div_q;
        if (load) begin
            neg_d    = A[N-1] ^ B[N-1];
            is_div_d = (op == OP_DIV);
        end
        if (cap_sc) begin
            out_d  = sc_out;
            o_d    = sc_o;
            c_d    = sc_c;
            done_d = 1'b1;
        end else if (cap_md) begin
            out_d  = md_out;
            o_d    = md_o;
            c_d    = 1'b0;
            done_d = 1'b1;
        end
        if (done_d) begin
            z_d  = (out_d == '0);
            nf_d = out_d[N-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            z_q      <= 1'b0;
            o_q      <= 1'b0;
            c_q      <= 1'b0;
            nf_q     <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            z_q      <= z_d;
            o_q      <= o_d;
            c_q      <= c_d;
            nf_q     <= nf_d;
            done_q   <= done_d;
            neg_q    <= neg_d;
            is_div_q <= is_div_d;
        end
    end

    assign out  = out_q;
    assign Z    = z_q;
    assign O    = o_q;
    assign C    = c_q;
    assign Nf   = nf_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with directed hand-computed vectors
module tb_alu_seq;

    localparam int N = 6;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   sel   = 3'b000;
    logic [N-1:0] A     = '0;
    logic [N-1:0] B     = '0;
    logic         busy, done, Z, O, C, Nf;
    logic [N-1:0] out;

    alu_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sel   (sel),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .Z     (Z),
        .O     (O),
        .C     (C),
        .Nf    (Nf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [N-1:0] out;
        logic         z, o, c, nf;
        int           done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_out"},     32'(out), 32'(mon_e.out));
                chk({mon_e.name, "_Z"},       32'(Z),   32'(mon_e.z));
                chk({mon_e.name, "_O"},       32'(O),   32'(mon_e.o));
                chk({mon_e.name, "_C"},       32'(C),   32'(mon_e.c));
                chk({mon_e.name, "_Nf"},      32'(Nf),  32'(mon_e.nf));
                chk({mon_e.name, "_latency"}, cyc,      mon_e.done_cyc);
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] eout, input logic ez,
                         input logic eo, input logic ec, input logic enf, input int lat);
        exp_t e;
        sel   = op;
        A     = a;
        B     = b;
        start = 1'b1;
        e.name     = name;
        e.out      = eout;
        e.z        = ez;
        e.o        = eo;
        e.c        = ec;
        e.nf       = enf;
        e.done_cyc = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done within 30 cycles expected done", name);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_sc(input string name, input logic [2:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] eout, input logic ez,
                          input logic eo, input logic ec, input logic enf);
        issue(name, op, a, b, eout, ez, eo, ec, enf, 1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        wait_idle(name);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_out"},  32'(out),  32'd0);
        chk({name, "_Z"},    32'(Z),    32'd0);
        chk({name, "_O"},    32'(O),    32'd0);
        chk({name, "_C"},    32'(C),    32'd0);
        chk({name, "_Nf"},   32'(Nf),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int bc;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        //     name        op      A          B          out        Z     O     C     Nf
        run_sc("add",      3'b000, 6'b000101, 6'b100011, 6'b000010, 1'b0, 1'b0, 1'b1, 1'b0);
        run_sc("add_ovf",  3'b000, 6'b010100, 6'b001111, 6'b000011, 1'b0, 1'b1, 1'b0, 1'b0);
        run_sc("add_zero", 3'b000, 6'b100111, 6'b000111, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_sc("sub",      3'b001, 6'b000011, 6'b000101, 6'b100010, 1'b0, 1'b0, 1'b0, 1'b1);
        run_sc("sub_nz",   3'b001, 6'b100000, 6'b000000, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_sc("and",      3'b110, 6'b110101, 6'b011100, 6'b010100, 1'b0, 1'b0, 1'b0, 1'b0);
        run_sc("or",       3'b111, 6'b100001, 6'b000110, 6'b100111, 1'b0, 1'b0, 1'b0, 1'b1);
        run_sc("div0",     3'b011, 6'b001001, 6'b100000, 6'b011111, 1'b0, 1'b1, 1'b0, 1'b0);
        run_sc("shl2",     3'b100, 6'b110001, 6'b000010, 6'b000100, 1'b0, 1'b0, 1'b1, 1'b0);
        run_sc("shr7",     3'b101, 6'b110001, 6'b000111, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_sc("shr1",     3'b101, 6'b110001, 6'b000001, 6'b011000, 1'b0, 1'b0, 1'b1, 1'b0);
        run_sc("shl0",     3'b100, 6'b101010, 6'b000000, 6'b101010, 1'b0, 1'b0, 1'b0, 1'b1);
        run_sc("shl5",     3'b100, 6'b110001, 6'b000101, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_sc("shl6",     3'b100, 6'b110001, 6'b000110, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);

        // mul with a start pulse injected while busy
        issue("mul", 3'b010, 6'b100101, 6'b000110, 6'b111110, 1'b0, 1'b0, 1'b0, 1'b1, 6);
        bc = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            bc++;
            if (bc == 2) begin
                sel   = 3'b000;
                A     = 6'b000001;
                B     = 6'b000001;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("mul_busy_cycles", bc, 5);
        wait_idle("mul");

        issue("div", 3'b011, 6'b011011, 6'b100100, 6'b100110, 1'b0, 1'b0, 1'b0, 1'b1, 6);
        wait_idle("div");
        issue("mul_ovf", 3'b010, 6'b001100, 6'b000011, 6'b000100, 1'b0, 1'b1, 1'b0, 1'b0, 6);
        wait_idle("mul_ovf");
        issue("mul_zero", 3'b010, 6'b100111, 6'b000000, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        wait_idle("mul_zero");

        // back-to-back: next start issued in the done cycle
        issue("div_b2b", 3'b011, 6'b000111, 6'b000010, 6'b000011, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        issue("add_b2b", 3'b000, 6'b000001, 6'b000001, 6'b000010, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        wait_idle("b2b");

        // reset asserted during the third busy cycle of a mul
        issue("mul_abort", 3'b010, 6'b000011, 6'b000011, 6'b001001, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1 chk_reset_state("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_busy_after", 32'(busy), 32'd0);
        run_sc("add_after", 3'b000, 6'b000010, 6'b000011, 6'b000101, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
